// File: rtl/fproc_meas_buf.sv
// Measurement buffer serving N_CORES fproc ports: per-channel sample store plus per-core NEXT/LATEST read FSMs.
// Optional WAIT timeout is enabled by defining FPROC_MEAS_TIMEOUT_EN.
module fproc_meas_buf #(
  parameter int N_CORES        = 5,
  parameter int N_MEAS         = N_CORES,
  parameter int MEAS_WIDTH     = 1,
  parameter int DATA_W         = 32,
  parameter int ID_W           = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MEAS*MEAS_WIDTH-1:0] meas,
  input  logic [N_MEAS-1:0]            meas_valid,
  input  logic [N_CORES-1:0]           core_enable,
  input  logic [N_CORES*ID_W-1:0]      core_id,
  output logic [N_CORES-1:0]           core_ready,
  output logic [N_CORES*DATA_W-1:0]    core_data
);

  localparam int ADDR_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int N_SLOT = 1 << ADDR_W;
  localparam logic [ADDR_W:0] N_MEAS_L = (ADDR_W + 1)'(N_MEAS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [MEAS_WIDTH-1:0] samp_q [N_MEAS];
  logic [N_MEAS-1:0]     seen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= '0;
      for (int k = 0; k < N_MEAS; k++) samp_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_MEAS; k++) begin
        if (meas_valid[k]) begin
          samp_q[k] <= meas[k*MEAS_WIDTH +: MEAS_WIDTH];
          seen_q[k] <= 1'b1;
        end
      end
    end
  end

  // Channel views padded to the full address space so any decoded chan indexes safely.
  logic [MEAS_WIDTH-1:0] meas_pad [N_SLOT];
  logic [MEAS_WIDTH-1:0] samp_pad [N_SLOT];
  logic [N_SLOT-1:0]     valid_pad;
  logic [N_SLOT-1:0]     seen_pad;

  always_comb begin
    valid_pad = '0;
    seen_pad  = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      meas_pad[k] = '0;
      samp_pad[k] = '0;
    end
    for (int k = 0; k < N_MEAS; k++) begin
      meas_pad[k]  = meas[k*MEAS_WIDTH +: MEAS_WIDTH];
      samp_pad[k]  = samp_q[k];
      valid_pad[k] = meas_valid[k];
      seen_pad[k]  = seen_q[k];
    end
  end

  logic unused_id;
  assign unused_id = ^core_id;

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   chan_q, chan_d;
    logic                mode_q, mode_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   resp_d;
    logic [ADDR_W-1:0]   req_chan;
    logic                req_mode;
    logic                req_oor;
`ifdef FPROC_MEAS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                expired;
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
`endif

    assign req_chan = core_id[c*ID_W +: ADDR_W];
    assign req_mode = core_id[c*ID_W + ADDR_W];
    assign req_oor  = ({1'b0, req_chan} >= N_MEAS_L);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        chan_q  <= '0;
        mode_q  <= 1'b0;
        ready_q <= 1'b0;
        data_q  <= '0;
`ifdef FPROC_MEAS_TIMEOUT_EN
        cnt_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        chan_q  <= chan_d;
        mode_q  <= mode_d;
        ready_q <= ready_d;
        data_q  <= data_d;
`ifdef FPROC_MEAS_TIMEOUT_EN
        cnt_q   <= cnt_d;
`endif
      end
    end

    // A valid in the request cycle completes LATEST immediately; NEXT only sees valids after it.
    always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      mode_d  = mode_q;
      resp_d  = '0;
      unique case (state_q)
        S_IDLE: begin
          if (core_enable[c]) begin
            chan_d = req_chan;
            mode_d = req_mode;
            if (req_oor) begin
              state_d = S_RESP;
            end else if (req_mode && valid_pad[req_chan]) begin
              state_d = S_RESP;
              resp_d  = DATA_W'(meas_pad[req_chan]);
            end else if (req_mode && seen_pad[req_chan]) begin
              state_d = S_RESP;
              resp_d  = DATA_W'(samp_pad[req_chan]);
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (valid_pad[chan_q]) begin
            state_d = S_RESP;
            resp_d  = DATA_W'(meas_pad[chan_q]);
          end
`ifdef FPROC_MEAS_TIMEOUT_EN
          else if (expired) begin
            state_d             = S_RESP;
            resp_d[DATA_W-1]    = 1'b1;
          end
`endif
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    always_comb begin
      ready_d = (state_d == S_RESP);
      data_d  = ready_d ? resp_d : '0;
    end

    assign core_ready[c]                 = ready_q;
    assign core_data[c*DATA_W +: DATA_W] = data_q;
  end

endmodule

// File: tb/tb_fproc_meas_buf.sv
// Directed bench for fproc_meas_buf: NEXT/LATEST reads, shared channel, out-of-range, reset, timeout.
module tb_fproc_meas_buf;

  localparam int NC = 5;
  localparam int NM = 5;
  localparam int MW = 4;
  localparam int DW = 32;
  localparam int IW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NM*MW-1:0] meas;
  logic [NM-1:0]    meas_valid;
  logic [NC-1:0]    core_enable;
  logic [NC*IW-1:0] core_id;
  logic [NC-1:0]    core_ready;
  logic [NC*DW-1:0] core_data;

  int vec  = 0;
  int miss = 0;

  fproc_meas_buf #(
    .N_CORES(NC), .N_MEAS(NM), .MEAS_WIDTH(MW), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .meas(meas), .meas_valid(meas_valid),
    .core_enable(core_enable), .core_id(core_id),
    .core_ready(core_ready), .core_data(core_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    core_enable = '0;
    meas_valid  = '0;
  endtask

  task automatic req(input int c, input logic [7:0] id);
    core_enable[c]      = 1'b1;
    core_id[c*IW +: IW] = id;
  endtask

  task automatic mv(input int ch, input logic [3:0] v);
    meas_valid[ch]      = 1'b1;
    meas[ch*MW +: MW]   = v;
  endtask

  function automatic logic [31:0] dat(input int c);
    return core_data[c*DW +: DW];
  endfunction

  initial begin
    reset = 1'b1; meas = '0; meas_valid = '0; core_enable = '0; core_id = '0;
    cyc(); cyc();
    chk("reset_ready", 32'(core_ready), 32'h0);
    chk("reset_data", core_data[31:0] | core_data[63:32] | core_data[159:128], 32'h0);
    reset = 1'b0;

    // 1: NEXT read on ch2, valid at t+5 -> ready at t+6
    req(0, 8'h02); cyc();
    chk("next_t1", 32'(core_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("next_wait", 32'(core_ready), 32'h0);
    end
    mv(2, 4'h1); cyc();
    chk("next_ready", 32'(core_ready), 32'h01);
    chk("next_data", dat(0), 32'h1);
    cyc();
    chk("next_pulse_end", 32'(core_ready), 32'h0);
    chk("next_data_clr", dat(0), 32'h0);

    // 2: NEXT ignores a valid coincident with the request
    req(1, 8'h01); mv(1, 4'h5); cyc();
    chk("coinc_t1", 32'(core_ready), 32'h0);
    cyc(); chk("coinc_t2", 32'(core_ready), 32'h0);
    cyc(); chk("coinc_t3", 32'(core_ready), 32'h0);
    mv(1, 4'h7); cyc();
    chk("coinc_ready", 32'(core_ready), 32'h02);
    chk("coinc_data", dat(1), 32'h7);
    cyc();

    // 3: LATEST hit on stored ch3, LATEST miss on unseen ch4, LATEST with coincident valid on ch0
    mv(3, 4'hA); cyc(); cyc();
    req(2, 8'h0B); cyc();
    chk("latest_hit_ready", 32'(core_ready), 32'h04);
    chk("latest_hit_data", dat(2), 32'hA);
    cyc();
    chk("latest_hit_end", 32'(core_ready), 32'h0);
    req(3, 8'h0C); cyc();
    chk("latest_unseen_t1", 32'(core_ready), 32'h0);
    cyc(); chk("latest_unseen_t2", 32'(core_ready), 32'h0);
    mv(4, 4'h6); cyc();
    chk("latest_unseen_ready", 32'(core_ready), 32'h08);
    chk("latest_unseen_data", dat(3), 32'h6);
    cyc();
    req(4, 8'h08); mv(0, 4'h3); cyc();
    chk("latest_coinc_ready", 32'(core_ready), 32'h10);
    chk("latest_coinc_data", dat(4), 32'h3);
    cyc();

    // 4: three cores share ch1, one valid completes all of them
    req(0, 8'h01); req(2, 8'h01); req(4, 8'h01); cyc();
    chk("shared_t1", 32'(core_ready), 32'h0);
    mv(1, 4'h0); cyc();
    chk("shared_ready", 32'(core_ready), 32'h15);
    chk("shared_data", dat(0) | dat(2) | dat(4), 32'h0);
    cyc();
    chk("shared_end", 32'(core_ready), 32'h0);

    // 5: out-of-range channel, then reset during WAIT
    req(1, 8'h06); cyc();
    chk("oor_ready", 32'(core_ready), 32'h02);
    chk("oor_data", dat(1), 32'h0);
    cyc();
    req(0, 8'h03); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst_wait_ready", 32'(core_ready), 32'h0);
    mv(3, 4'h5); cyc();
    chk("rst_dropped", 32'(core_ready), 32'h0);
    cyc(); chk("rst_dropped2", 32'(core_ready), 32'h0);
    req(2, 8'h0A); cyc();
    chk("rst_seen_clr", 32'(core_ready), 32'h0);
    mv(2, 4'h9); cyc();
    chk("rst_after_ready", 32'(core_ready), 32'h04);
    chk("rst_after_data", dat(2), 32'h9);
    cyc();

`ifdef FPROC_MEAS_TIMEOUT_EN
    // 6: timeout after 8 WAIT cycles, and valid at expiry beats the timeout
    req(0, 8'h02); cyc();
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("to_wait", 32'(core_ready), 32'h0);
    end
    cyc();
    chk("to_ready", 32'(core_ready), 32'h01);
    chk("to_data", dat(0), 32'h8000_0000);
    cyc();
    req(0, 8'h02); cyc();
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("to_race_wait", 32'(core_ready), 32'h0);
    end
    mv(2, 4'h5); cyc();
    chk("to_race_ready", 32'(core_ready), 32'h01);
    chk("to_race_data", dat(0), 32'h5);
    cyc();
`else
    // 6: without timeout, WAIT persists until a valid arrives
    req(0, 8'h02); cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("hold_wait", 32'(core_ready), 32'h0);
    end
    mv(2, 4'h5); cyc();
    chk("hold_ready", 32'(core_ready), 32'h01);
    chk("hold_data", dat(0), 32'h5);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
